// File: rtl/usb_host_pkg.sv
// Shared USB host types: field widths, transaction result codes, arbiter state
// encoding and the per-requester request slot.
package usb_host_pkg;
   localparam int ADDR_W = 7;
   localparam int ENDP_W = 4;
   localparam int RES_W  = 3;
   localparam int GID_W  = 3;

   typedef enum logic [RES_W-1:0] {
      RES_NONE    = 3'd0,
      RES_ACK     = 3'd1,
      RES_NAK     = 3'd2,
      RES_STALL   = 3'd3,
      RES_TIMEOUT = 3'd4,
      RES_CRC     = 3'd5
   } usb_result_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_BUSY,
      ST_COMPLETE
   } arb_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [ENDP_W-1:0] endp;
      logic              pid;
   } usb_slot_t;
endpackage

// File: rtl/usb_rr_picker.sv
// Combinational round-robin picker: the pending requester nearest after
// last_grant (wrapping) wins.
module usb_rr_picker
   import usb_host_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] i_pending,
   input  logic [GID_W-1:0]   i_last_grant,
   output logic               o_found,
   output logic [GID_W-1:0]   o_winner
);
   int w_dist;
   int w_best;

   always_comb begin
      o_found  = 1'b0;
      o_winner = '0;
      w_best   = NUM_REQ;
      w_dist   = 0;
      for (int j = 0; j < NUM_REQ; j++) begin
         // distance 0 is the slot right after the last grant
         w_dist = (j - int'(i_last_grant) - 1 + 2 * NUM_REQ) % NUM_REQ;
         if (i_pending[j] && (w_dist < w_best)) begin
            w_best   = w_dist;
            o_winner = GID_W'(j);
            o_found  = 1'b1;
         end
      end
   end
endmodule

// File: rtl/usb_trans_arbiter.sv
// Shares one USB transaction engine among NUM_REQ host engines: latches
// requests per slot, grants round-robin, and guards the engine with a watchdog.
module usb_trans_arbiter
   import usb_host_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int WDOG_CYCLES = 6000000
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_enable,
   input  logic [NUM_REQ-1:0]        i_req_start,
   input  logic [ADDR_W*NUM_REQ-1:0] i_req_addr,
   input  logic [ENDP_W*NUM_REQ-1:0] i_req_endp,
   input  logic [NUM_REQ-1:0]        i_req_data_pid,
   input  logic [NUM_REQ-1:0]        i_req_data_out_ready,
   output logic [NUM_REQ-1:0]        o_req_pending,
   output logic [NUM_REQ-1:0]        o_req_done,
   output logic [RES_W-1:0]          o_req_result,
   output logic [7:0]                o_req_data_out,
   output logic [NUM_REQ-1:0]        o_req_data_out_valid,
   output logic                      o_eng_start,
   output logic [ADDR_W-1:0]         o_eng_addr,
   output logic [ENDP_W-1:0]         o_eng_endp,
   output logic                      o_eng_data_pid,
   input  logic                      i_eng_done,
   input  logic [RES_W-1:0]          i_eng_result,
   input  logic [7:0]                i_eng_data_out,
   input  logic                      i_eng_data_out_valid,
   output logic                      o_eng_data_out_ready,
   output logic [GID_W-1:0]          o_grant_id,
   output logic                      o_grant_active,
   output logic                      o_wdog_error
);
   localparam int WD_W = $clog2(WDOG_CYCLES + 1);

   arb_state_e                r_state, w_next;
   usb_slot_t [NUM_REQ-1:0]   r_slot;
   logic      [NUM_REQ-1:0]   r_pend;
   logic      [GID_W-1:0]     r_gid, r_last;
   usb_slot_t                 r_eng, w_win_slot;
   logic      [RES_W-1:0]     r_result;
   logic                      r_wdog_err;
   logic      [WD_W-1:0]      r_wdog;
   logic                      w_found;
   logic      [GID_W-1:0]     w_winner;
   logic      [NUM_REQ-1:0]   w_gid_oh;
   logic                      w_complete, w_active, w_timeout;

   usb_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .i_pending    (r_pend),
      .i_last_grant (r_last),
      .o_found      (w_found),
      .o_winner     (w_winner)
   );

   always_comb begin
      w_gid_oh   = '0;
      w_win_slot = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_gid_oh[i] = (r_gid == GID_W'(i));
         if (w_winner == GID_W'(i)) w_win_slot = r_slot[i];
      end
   end

   assign w_complete = (r_state == ST_COMPLETE);
   assign w_active   = (r_state == ST_ISSUE) || (r_state == ST_BUSY);
   assign w_timeout  = (r_state == ST_BUSY) && (r_wdog == WD_W'(WDOG_CYCLES - 1));

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:     if (i_enable && w_found) w_next = ST_ISSUE;
         ST_ISSUE:    w_next = ST_BUSY;
         ST_BUSY:     if (i_eng_done || w_timeout) w_next = ST_COMPLETE;
         ST_COMPLETE: w_next = ST_IDLE;
         default:     w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pend     <= '0;
         r_slot     <= '0;
         r_gid      <= '0;
         r_last     <= GID_W'(NUM_REQ - 1);
         r_eng      <= '0;
         r_result   <= '0;
         r_wdog_err <= 1'b0;
         r_wdog     <= '0;
      end else begin
         // a restart from the owner in its COMPLETE cycle beats the clear
         for (int i = 0; i < NUM_REQ; i++) begin
            if (i_req_start[i] && (!r_pend[i] || (w_complete && w_gid_oh[i]))) begin
               r_pend[i]      <= 1'b1;
               r_slot[i].addr <= i_req_addr[i*ADDR_W +: ADDR_W];
               r_slot[i].endp <= i_req_endp[i*ENDP_W +: ENDP_W];
               r_slot[i].pid  <= i_req_data_pid[i];
            end else if (w_complete && w_gid_oh[i]) begin
               r_pend[i] <= 1'b0;
            end
         end
         case (r_state)
            ST_IDLE: if (i_enable && w_found) begin
               r_gid <= w_winner;
               r_eng <= w_win_slot;
            end
            ST_ISSUE: r_wdog <= '0;
            ST_BUSY: begin
               if (i_eng_done) begin
                  r_result <= i_eng_result;
               end else if (w_timeout) begin
                  r_result   <= RES_TIMEOUT;
                  r_wdog_err <= 1'b1;
               end else begin
                  r_wdog <= r_wdog + WD_W'(1);
               end
            end
            ST_COMPLETE: r_last <= r_gid;
            default: ;
         endcase
      end
   end

   assign o_req_pending        = r_pend;
   assign o_req_done           = w_complete ? w_gid_oh : '0;
   assign o_req_result         = w_complete ? r_result : '0;
   assign o_req_data_out       = i_eng_data_out;
   assign o_req_data_out_valid = {NUM_REQ{i_eng_data_out_valid && w_active}} & w_gid_oh;
   assign o_eng_start          = (r_state == ST_ISSUE);
   assign o_eng_addr           = r_eng.addr;
   assign o_eng_endp           = r_eng.endp;
   assign o_eng_data_pid       = r_eng.pid;
   assign o_eng_data_out_ready = w_active && |(i_req_data_out_ready & w_gid_oh);
   assign o_grant_id           = r_gid;
   assign o_grant_active       = w_active;
   assign o_wdog_error         = r_wdog_err;
endmodule

// File: tb/tb_usb_trans_arbiter.sv
// Directed bench for usb_trans_arbiter: single request, contention, fairness,
// data routing, watchdog, enable/duplicate/reset boundaries.
module tb_usb_trans_arbiter;
   import usb_host_pkg::*;
   localparam int N = 4;

   logic            clk = 1'b0;
   logic            rst, enable;
   logic [N-1:0]    req_start, req_pid, req_ready;
   logic [7*N-1:0]  req_addr;
   logic [4*N-1:0]  req_endp;
   logic [N-1:0]    req_pending, req_done, req_dvalid;
   logic [2:0]      req_result;
   logic [7:0]      req_data;
   logic            eng_start, eng_pid, eng_done, eng_dvalid, eng_ready;
   logic [6:0]      eng_addr;
   logic [3:0]      eng_endp;
   logic [2:0]      eng_result, grant_id;
   logic [7:0]      eng_data;
   logic            grant_active, wdog_error;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   usb_trans_arbiter #(.NUM_REQ(N), .WDOG_CYCLES(100)) dut (
      .i_clk(clk), .i_rst(rst), .i_enable(enable),
      .i_req_start(req_start), .i_req_addr(req_addr), .i_req_endp(req_endp),
      .i_req_data_pid(req_pid), .i_req_data_out_ready(req_ready),
      .o_req_pending(req_pending), .o_req_done(req_done), .o_req_result(req_result),
      .o_req_data_out(req_data), .o_req_data_out_valid(req_dvalid),
      .o_eng_start(eng_start), .o_eng_addr(eng_addr), .o_eng_endp(eng_endp),
      .o_eng_data_pid(eng_pid), .i_eng_done(eng_done), .i_eng_result(eng_result),
      .i_eng_data_out(eng_data), .i_eng_data_out_valid(eng_dvalid),
      .o_eng_data_out_ready(eng_ready), .o_grant_id(grant_id),
      .o_grant_active(grant_active), .o_wdog_error(wdog_error)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_slot(input int i, input logic [6:0] a, input logic [3:0] e, input logic p);
      req_addr[i*7 +: 7] = a;
      req_endp[i*4 +: 4] = e;
      req_pid[i]         = p;
   endtask

   task automatic pulse(input logic [N-1:0] mask);
      req_start = mask;
      tick();
      req_start = '0;
   endtask

   task automatic wait_start();
      for (int k = 0; k < 50; k++) begin
         if (eng_start) break;
         tick();
      end
      check("eng_start_seen", 32'(eng_start), 32'd1);
   endtask

   // Grant check, ACK from the engine, optional restart in the COMPLETE cycle.
   task automatic serve(input int id, input logic [2:0] res, input logic [6:0] exp_addr,
                        input logic rereq, input logic [6:0] new_addr);
      logic [N-1:0] exp_done;
      exp_done = 4'b0001 << id;
      wait_start();
      check("grant_id", 32'(grant_id), 32'(id));
      check("eng_addr", 32'(eng_addr), 32'(exp_addr));
      tick();
      eng_result = res;
      eng_done   = 1'b1;
      tick();
      eng_done = 1'b0;
      check("req_done", 32'(req_done), 32'(exp_done));
      check("req_result", 32'(req_result), 32'(res));
      if (rereq) begin
         set_slot(id, new_addr, 4'd0, 1'b0);
         pulse(exp_done);
         check("rereq_pending", 32'(req_pending & exp_done), 32'(exp_done));
      end else begin
         tick();
      end
   endtask

   initial begin
      int cnt;
      logic saw;
      rst = 1'b1; enable = 1'b1; req_start = '0; req_pid = '0; req_ready = '0;
      req_addr = '0; req_endp = '0; eng_done = 1'b0; eng_result = '0;
      eng_data = '0; eng_dvalid = 1'b0;
      tick(); tick();
      rst = 1'b0;
      check("rst_pending", 32'(req_pending), 32'd0);
      check("rst_done", 32'(req_done), 32'd0);
      check("rst_active", 32'(grant_active), 32'd0);
      check("rst_eng_start", 32'(eng_start), 32'd0);
      check("rst_eng_fields", 32'({eng_addr, eng_endp, eng_pid}), 32'd0);
      check("rst_gid", 32'(grant_id), 32'd0);

      // single request on slot 2
      set_slot(2, 7'h05, 4'd1, 1'b1);
      pulse(4'b0100);
      check("single_pending", 32'(req_pending), 32'h4);
      check("single_no_start_t1", 32'(eng_start), 32'd0);
      tick();
      check("single_start_t2", 32'(eng_start), 32'd1);
      check("single_fields", 32'({eng_addr, eng_endp, eng_pid}), 32'({7'h05, 4'd1, 1'b1}));
      check("single_gid", 32'(grant_id), 32'd2);
      check("single_active", 32'(grant_active), 32'd1);
      tick();
      check("single_start_1cyc", 32'(eng_start), 32'd0);
      eng_result = 3'd1; eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      check("single_done", 32'(req_done), 32'h4);
      check("single_result", 32'(req_result), 32'd1);
      tick();
      check("single_done_1cyc", 32'(req_done), 32'd0);
      check("single_cleared", 32'(req_pending), 32'd0);

      // contention: two full bursts, expected order 0,1,2,3 each time
      rst = 1'b1; tick(); rst = 1'b0;
      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < N; i++) set_slot(i, 7'(8'h10 + 8'(16 * b) + 8'(i)), 4'(i), 1'(i));
         pulse(4'b1111);
         for (int i = 0; i < N; i++) serve(i, 3'd1, 7'(8'h10 + 8'(16 * b) + 8'(i)), 1'b0, 7'h0);
      end

      // fairness: 0 and 1 re-request on each completion
      set_slot(0, 7'h30, 4'd0, 1'b0);
      set_slot(1, 7'h31, 4'd0, 1'b0);
      pulse(4'b0011);
      for (int k = 0; k < 6; k++)
         serve(k % 2, 3'd1, (k < 2) ? 7'(8'h30 + 8'(k)) : 7'(8'h40 + 8'(k - 2)),
               1'(k < 4), 7'(8'h40 + 8'(k)));

      // data routing with grant on 1
      set_slot(1, 7'h11, 4'd2, 1'b0);
      pulse(4'b0010);
      wait_start();
      check("route_gid", 32'(grant_id), 32'd1);
      tick();
      req_ready = 4'b0010; #1;
      check("route_ready_hi", 32'(eng_ready), 32'd1);
      req_ready = 4'b1101; #1;
      check("route_ready_lo", 32'(eng_ready), 32'd0);
      for (int b = 1; b <= 3; b++) begin
         eng_data = 8'(b); eng_dvalid = 1'b1; #1;
         check("route_valid", 32'(req_dvalid), 32'h2);
         check("route_byte", 32'(req_data), 32'(b));
         eng_dvalid = 1'b0; #1;
         check("route_valid_off", 32'(req_dvalid), 32'd0);
         tick();
      end
      eng_result = 3'd1; eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      check("route_done", 32'(req_done), 32'h2);
      tick();
      req_ready = 4'b1111; eng_dvalid = 1'b1; #1;
      check("idle_ready", 32'(eng_ready), 32'd0);
      check("idle_valid", 32'(req_dvalid), 32'd0);
      req_ready = '0; eng_dvalid = 1'b0;

      // watchdog: slot 3 never completes, slot 0 waits behind it
      set_slot(3, 7'h53, 4'd3, 1'b1);
      set_slot(0, 7'h50, 4'd0, 1'b0);
      pulse(4'b1001);
      wait_start();
      check("wdog_gid", 32'(grant_id), 32'd3);
      tick();
      cnt = 1;
      while (req_done == '0 && cnt < 300) begin
         tick();
         cnt++;
      end
      check("wdog_latency", 32'(cnt), 32'd101);
      check("wdog_done", 32'(req_done), 32'h8);
      check("wdog_result", 32'(req_result), 32'd4);
      check("wdog_error", 32'(wdog_error), 32'd1);
      tick();
      serve(0, 3'd1, 7'h50, 1'b0, 7'h0);
      check("wdog_sticky", 32'(wdog_error), 32'd1);

      // enable low blocks grants; duplicate start leaves original fields
      enable = 1'b0;
      set_slot(2, 7'h22, 4'd2, 1'b0);
      pulse(4'b0100);
      set_slot(2, 7'h33, 4'd5, 1'b1);
      pulse(4'b0100);
      saw = 1'b0;
      repeat (10) begin
         if (eng_start) saw = 1'b1;
         tick();
      end
      check("en_low_no_start", 32'(saw), 32'd0);
      check("en_low_pending", 32'(req_pending), 32'h4);
      enable = 1'b1;
      wait_start();
      check("dup_fields", 32'({eng_addr, eng_endp, eng_pid}), 32'({7'h22, 4'd2, 1'b0}));
      tick();
      check("busy_active", 32'(grant_active), 32'd1);

      // reset in BUSY drops the transaction
      rst = 1'b1; tick(); rst = 1'b0;
      check("rstb_pending", 32'(req_pending), 32'd0);
      check("rstb_active", 32'(grant_active), 32'd0);
      check("rstb_eng", 32'({eng_start, eng_addr, eng_endp, eng_pid}), 32'd0);
      check("rstb_wdog", 32'(wdog_error), 32'd0);
      check("rstb_gid", 32'(grant_id), 32'd0);
      saw = 1'b0;
      eng_result = 3'd1;
      repeat (5) begin
         eng_done = 1'b1;
         if (req_done != '0) saw = 1'b1;
         tick();
      end
      eng_done = 1'b0;
      check("rstb_no_done", 32'(saw), 32'd0);

      // after reset last_grant is N-1, so lowest pending index wins
      set_slot(1, 7'h61, 4'd1, 1'b0);
      set_slot(2, 7'h62, 4'd2, 1'b0);
      pulse(4'b0110);
      serve(1, 3'd2, 7'h61, 1'b0, 7'h0);
      serve(2, 3'd5, 7'h62, 1'b0, 7'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, checks=%0d", n_chk);
      $fatal(1);
   end
endmodule
